// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the signed-result to BCD converter:
// FSM encoding, default sizes and the double-dabble adjust threshold.
package result_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int DEF_IN_W   = 20;
    localparam int DEF_DIGITS = 6;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/result_bcd_converter_digit_adjust.sv
// One BCD digit of the double-dabble step: add 3 when the digit would
// overflow past 9 after the next left shift.
module bcd_digit_adjust
    import result_bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/result_bcd_converter.sv
// Converts a two's-complement result into sign + packed BCD magnitude using
// an iterative double-dabble, one bit per clock, with leading-zero mask.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       result,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IN_W-1:0]  IN_ONE   = IN_W'(1);

    state_t                  state;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_adj;
    logic [IN_W-1:0]         mag;
    logic [IN_W-1:0]         abs_result;
    logic [CNT_W-1:0]        cnt;
    logic                    sign_q;
    logic [DIGITS-1:0]       en_next;
    logic [ACC_W+IN_W-1:0]   shifted;

    // The most negative input negates to itself, which is the correct unsigned magnitude.
    assign abs_result = result[IN_W-1] ? (~result + IN_ONE) : result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (acc[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

    assign shifted = {acc_adj, mag} << 1;

    always_comb begin
        logic any_above;
        any_above = 1'b0;
        en_next   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_above  = any_above | (|acc[4*i +: 4]);
            en_next[i] = any_above;
        end
        en_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            negative <= 1'b0;
            digit_en <= DIGITS'(1);
            cnt      <= '0;
            acc      <= '0;
            mag      <= '0;
            sign_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= result[IN_W-1];
                        mag    <= abs_result;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= shifted[ACC_W+IN_W-1:IN_W];
                    mag <= shifted[IN_W-1:0];
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST_CNT) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd      <= acc;
                    negative <= sign_q;
                    digit_en <= en_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed and reference-model checks for result_bcd_converter at its
// default 20-bit input / 6-digit output configuration.
module tb_result_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] result;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
    logic        negative;
    logic [5:0]  digit_en;

    int compared   = 0;
    int mismatched = 0;

    result_bcd_converter #(.IN_W(20), .DIGITS(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .negative (negative),
        .digit_en (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; lat counts edges after the start-sampling edge.
    task automatic waitDone(output int lat, output logic busy_seen);
        lat       = 0;
        busy_seen = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) busy_seen = busy;
            if (done) break;
        end
    endtask

    task automatic applyStimulus(input logic [19:0] r, output int lat, output logic busy_seen);
        @(negedge clk);
        start  = 1'b1;
        result = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        result = ~r;
        waitDone(lat, busy_seen);
    endtask

    task automatic checkConversion(input string tag, input int lat, input logic [23:0] exp_bcd,
                                   input logic exp_neg, input logic [5:0] exp_en);
        checkOutput({tag, ".latency"}, 32'(lat), 32'd21);
        checkOutput({tag, ".bcd"}, 32'(bcd), 32'(exp_bcd));
        checkOutput({tag, ".negative"}, 32'(negative), 32'(exp_neg));
        checkOutput({tag, ".digit_en"}, 32'(digit_en), 32'(exp_en));
    endtask

    function automatic logic [23:0] refBcd(input int unsigned m);
        logic [23:0] r;
        int unsigned v;
        r = '0;
        v = m;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] refEn(input int unsigned m);
        logic [5:0] e;
        int unsigned limit;
        e     = 6'b000001;
        limit = 10;
        for (int i = 1; i < 6; i++) begin
            if (m >= limit) e[i] = 1'b1;
            limit = limit * 10;
        end
        return e;
    endfunction

    initial begin
        int   lat;
        logic busy_seen;
        int   pulses;
        int   done_at;

        rst_n  = 1'b0;
        start  = 1'b0;
        result = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.bcd", 32'(bcd), 32'd0);
        checkOutput("reset.negative", 32'(negative), 32'd0);
        checkOutput("reset.digit_en", 32'(digit_en), 32'b000001);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(20'd12345, lat, busy_seen);
        checkOutput("pos12345.busy_during", 32'(busy_seen), 32'd1);
        checkConversion("pos12345", lat, 24'h012345, 1'b0, 6'b011111);
        @(posedge clk);
        #1;
        checkOutput("pos12345.done_one_cycle", 32'(done), 32'd0);
        checkOutput("pos12345.busy_after", 32'(busy), 32'd0);
        checkOutput("pos12345.bcd_hold", 32'(bcd), 32'h012345);

        applyStimulus(20'hFFFFF, lat, busy_seen);
        checkConversion("minus1", lat, 24'h000001, 1'b1, 6'b000001);

        applyStimulus(20'hE0001, lat, busy_seen);
        checkConversion("minus131071", lat, 24'h131071, 1'b1, 6'b111111);

        applyStimulus(20'h80000, lat, busy_seen);
        checkConversion("most_negative", lat, 24'h524288, 1'b1, 6'b111111);

        applyStimulus(20'd0, lat, busy_seen);
        checkConversion("zero", lat, 24'h000000, 1'b0, 6'b000001);

        // Start during busy must be dropped; start in the done cycle must be taken.
        @(negedge clk);
        start  = 1'b1;
        result = 20'd100;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pulses  = 0;
        done_at = 0;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                done_at = k;
            end
            if (k == 4) begin
                start  = 1'b1;
                result = 20'd7;
            end else if (k == 5) begin
                start = 1'b0;
            end
        end
        checkOutput("busy_start.pulses", 32'(pulses), 32'd1);
        checkOutput("busy_start.done_edge", 32'(done_at), 32'd21);
        checkOutput("busy_start.bcd", 32'(bcd), 32'h000100);
        start  = 1'b1;
        result = 20'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, busy_seen);
        checkConversion("back_to_back", lat, 24'h000007, 1'b0, 6'b000001);

        @(negedge clk);
        start  = 1'b1;
        result = 20'd999;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (k == 9) rst_n = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("mid_reset.busy", 32'(busy), 32'd0);
        checkOutput("mid_reset.done", 32'(done), 32'd0);
        checkOutput("mid_reset.bcd", 32'(bcd), 32'd0);
        checkOutput("mid_reset.digit_en", 32'(digit_en), 32'b000001);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("mid_reset.no_done", 32'(pulses), 32'd0);

        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b1;
        result = 20'd55;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        checkOutput("reset_start.ignored", 32'(pulses), 32'd0);

        applyStimulus(20'd4321, lat, busy_seen);
        checkConversion("after_reset", lat, 24'h004321, 1'b0, 6'b001111);

        for (int n = 0; n < 1000; n++) begin
            int          a;
            int          b;
            int          v;
            int unsigned m;
            a = int'($urandom_range(0, 131071));
            b = int'($urandom_range(0, 131071));
            v = a - b;
            m = (v < 0) ? int'(-v) : v;
            applyStimulus(20'(v), lat, busy_seen);
            checkConversion($sformatf("rand%0d", n), lat, refBcd(m), (v < 0), refEn(m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port is named clk and the reset port is named rst_n.
REQ-002 Parameter IN_W, default 20, SHALL set the width of the two's-complement result input.
REQ-003 Parameter DIGITS, default 6, SHALL set the number of BCD output digits; DIGITS SHALL be large enough for the magnitude 2^(IN_W-1).
REQ-004 Port clk SHALL be an input, 1 bit wide: the rising-edge system clock.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: synchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit wide: a request to convert result, sampled only in IDLE.
REQ-007 Port result SHALL be an input, IN_W bits wide: the two's-complement difference from the upstream subtractor.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while a conversion is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse when bcd, negative and digit_en update.
REQ-010 Port bcd SHALL be an output, 4*DIGITS bits wide: the magnitude as packed BCD, least significant digit in [3:0].
REQ-011 Port negative SHALL be an output, 1 bit wide: the sign of the converted result.
REQ-012 Port digit_en SHALL be an output, DIGITS bits wide: significant-digit mask for leading-zero blanking.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and FINISH.
REQ-014 IDLE: when start=1 at a rising edge (E0), the block SHALL capture negative=result[IN_W-1] and magnitude=|result| as an unsigned IN_W-bit value, clear the BCD accumulator, set busy=1 and go to SHIFT.
REQ-015 SHIFT: on each of edges E1..E_IN_W, the block SHALL add 3 to every accumulator digit that is at least 5, then shift {accumulator, magnitude} left by one bit (double-dabble); a counter SHALL track the IN_W iterations.
REQ-016 After the final shift, on edge E(IN_W+1), the block SHALL register bcd, negative and digit_en, assert done for exactly one cycle, clear busy and return to IDLE.
REQ-017 Fixed latency SHALL be IN_W+1 edges from the start-sampling edge to done (21 edges at the defaults).
REQ-018 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-019 A start asserted in the cycle where done=1 SHALL be accepted, because the FSM is already in IDLE, so back-to-back conversions are possible.
REQ-020 Between updates, bcd, negative and digit_en SHALL hold their last values.
REQ-021 Magnitude of the most negative input (result = 2^(IN_W-1)) SHALL convert correctly without overflow: 20'h80000 gives bcd 0x524288 with negative=1.
REQ-022 A zero result SHALL give negative=0.
REQ-023 digit_en[i] SHALL be 1 if digit i or any higher digit is non-zero; digit_en[0] SHALL always be 1.
REQ-024 result SHALL be sampled only at E0; changes to result during SHIFT SHALL have no effect.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL go to IDLE and set busy=0, done=0, bcd=0, negative=0, digit_en=1 and the internal counter and accumulator to 0.
REQ-026 A reset asserted mid-conversion SHALL abort the conversion without producing a done pulse; outputs SHALL take the values in REQ-025.
REQ-027 A start that coincides with rst_n=0 SHALL be ignored.

Structure
REQ-028 The shared package SHALL hold the FSM state encoding, the IN_W and DIGITS defaults, and the add-3 threshold constant.
REQ-029 The per-digit conditional add-3 SHALL be a sub-module named bcd_digit_adjust (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Stimulus result=20'd12345, start pulse: done after 21 edges; bcd=0x012345, negative=0, digit_en=6'b011111.
REQ-032 Stimulus result=20'hFFFFF (-1): bcd=0x000001, negative=1, digit_en=6'b000001; result=20'hE0001 (-131071): bcd=0x131071, negative=1.
REQ-033 Stimulus result=20'h80000: bcd=0x524288, negative=1, digit_en=6'b111111; result=0: bcd=0x000000, negative=0, digit_en=6'b000001.
REQ-034 Start with result=100, then start with result=7 on edge E5: only one done pulse, bcd=0x000100; a third start with result=7 in the done cycle: second done 21 edges later with bcd=0x000007.
REQ-035 rst_n=0 on edge E10 of a conversion: no done pulse, bcd=0, busy=0; a new start after release converts normally.
REQ-036 Randomized check against a reference model: 1000 random 17-bit pairs (a, b) with result=a-b, each conversion checking bcd, negative and digit_en.
